// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: diff_ext = a - b - bin, one DIGIT_WIDTH slice per cycle, LSB first.
// Result MSB is the borrow-out, matching the adder's DATA_WIDTH+1 extended-result format.
module digit_serial_subtractor #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DIGIT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   diff_ext,
    output logic                  busy
);

    // Same ceiling-log2 as adder_pkg::clog2, kept local so the block elaborates standalone.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int unsigned NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    localparam int unsigned CNT_W      = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);

    if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_width_check
        $error("DIGIT_WIDTH must divide DATA_WIDTH exactly");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    borrow_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [DATA_WIDTH:0]     res_q;

    logic [DIGIT_WIDTH:0]              dsub;
    logic [DATA_WIDTH+DIGIT_WIDTH-1:0] res_cat;
    logic [DATA_WIDTH-1:0]             res_shift;
    logic                              last_digit;

    // Operands shift right each cycle, so the current digit is always the low slice;
    // result digits enter at the top and have walked down to their place after NUM_DIGITS.
    always_comb begin
        dsub       = {1'b0, a_q[DIGIT_WIDTH-1:0]} - {1'b0, b_q[DIGIT_WIDTH-1:0]}
                     - {{DIGIT_WIDTH{1'b0}}, borrow_q};
        res_cat    = {dsub[DIGIT_WIDTH-1:0], res_q[DATA_WIDTH-1:0]};
        res_shift  = res_cat[DATA_WIDTH+DIGIT_WIDTH-1:DIGIT_WIDTH];
        last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    a_q                   <= a_q >> DIGIT_WIDTH;
                    b_q                   <= b_q >> DIGIT_WIDTH;
                    borrow_q              <= dsub[DIGIT_WIDTH];
                    res_q[DATA_WIDTH-1:0] <= res_shift;
                    cnt_q                 <= cnt_q + CNT_W'(1);
                    if (last_digit) begin
                        res_q[DATA_WIDTH] <= dsub[DIGIT_WIDTH];
                        state_q           <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign diff_ext  = res_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Self-checking bench for digit_serial_subtractor: vector table, handshake corners, random sweep.
module tb_digit_serial_subtractor;

    localparam int unsigned DW  = 32;
    localparam int unsigned NDG = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          bin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW:0]   diff_ext;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          bin;
        logic [DW:0]   exp;
    } vec_t;

    vec_t vecs[7];

    digit_serial_subtractor #(.DATA_WIDTH(DW), .DIGIT_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_ext  (diff_ext),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic c);
        return {1'b0, x} - {1'b0, y} - {{DW{1'b0}}, c};
    endfunction

    // Drive operands, wait (bounded) for in_ready, complete the accept edge, push expected.
    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic c,
                        input logic [DW:0] exp);
        int n;
        a = x; b = y; bin = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        step();
        in_valid = 1'b0;
        exp_q.push_back(exp);
    endtask

    // Wait (bounded) for out_valid after an accept, then check latency and pop/compare.
    task automatic get_result(input string name, input bit chk_lat);
        int n;
        logic [DW:0] e;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout: out_valid stayed 0, required 1", name);
            return;
        end
        if (chk_lat) chk({name, "_latency"}, 64'(n), 64'(NDG));
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard: result 0x%0h with empty queue", name, diff_ext);
            return;
        end
        e = exp_q.pop_front();
        chk(name, 64'(diff_ext), 64'(e));
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic          rc;
        logic [DW-1:0] rt;
        int            seen;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 33'h0_0000_0002};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 33'h1_FFFF_FFFF};
        vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 33'h1_FFFF_FFFF};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 33'h0_7FFF_FFFE};
        vecs[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 33'h0_DEAD_BEEF};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 33'h1_FFFF_FFFF};
        vecs[6] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 33'h1_0000_0000};

        // Reset state
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff_ext", 64'(diff_ext), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // Vector table with out_ready held high: latency and single-cycle valid
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);
            get_result($sformatf("vec%0d", i), 1'b1);
            step();
            chk($sformatf("vec%0d_valid_drop", i), 64'(out_valid), 64'd0);
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
        end

        // Backpressure: result held, new operands ignored while busy
        out_ready = 1'b0;
        send(32'h5, 32'h3, 1'b0, 33'h0_0000_0002);
        get_result("bp_result", 1'b1);
        a = 32'h7777_0000; b = 32'h1; bin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d_diff_ext", i), 64'(diff_ext), 64'h0_0000_0002);
            chk($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
            chk($sformatf("bp%0d_busy", i), 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        step();
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        send(32'h0000_0100, 32'h0000_0001, 1'b0, 33'h0_0000_00FF);
        get_result("bp_next", 1'b1);
        step();

        // Reset on the second CALC edge discards the operation
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 33'h0);
        void'(exp_q.pop_back());
        step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_diff_ext", 64'(diff_ext), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("rst_mid_no_result", 64'(seen), 64'd0);
        send(32'hA, 32'h4, 1'b0, 33'h0_0000_0006);
        get_result("post_rst", 1'b1);
        step();

        // Random sweep against the reference model plus an add-back round trip
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = ra;
            send(ra, rb, rc, model(ra, rb, rc));
            get_result($sformatf("rnd%0d", i), 1'b0);
            rt = diff_ext[DW-1:0] + rb + {{(DW-1){1'b0}}, rc};
            chk($sformatf("rnd%0d_roundtrip", i), 64'(rt), 64'(ra));
            step();
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
